multdiv_seq: RTL and testbench

- Parametrised sequential multiply/divide unit for the processor's execute stage; it is the next generation of the fixed 32-bit multdiv.
- A single shared WIDTH-bit add/subtract datapath runs shift-add multiply or restoring divide, one bit per clock.
- New capabilities: configurable width, a signed/unsigned mode, full 2*WIDTH product, remainder output, a busy flag with an explicit start rule, and defined corner-case results.

---
 rtl/multdiv_seq_if.sv | 20 ++
 rtl/multdiv_seq.sv | 122 ++++++++++++
 tb/tb_multdiv_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/multdiv_seq_if.sv
// multdiv_seq_if: operand, control and result bundle between the execute stage and multdiv_seq
interface multdiv_seq_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic ctrl_MULT;
  logic ctrl_DIV;
  logic ctrl_signed;
  logic [2*WIDTH-1:0] data_result;
  logic data_exception;
  logic data_resultRDY;
  logic busy;
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_signed,
    input data_result, data_exception, data_resultRDY, busy
  );
  modport slave (
    input data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_signed,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_seq.sv
// multdiv_seq: shift-add multiply / restoring divide sharing one add/sub datapath, one bit per clock
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic clock,
  input logic clrn,
  multdiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d, m_q, m_d;
  logic div_q, div_d, sgn_q, sgn_d, neg_q, neg_d, dneg_q, dneg_d, dz_q, dz_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic start, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
  logic [WIDTH:0] trial;
  logic [WIDTH+1:0] sum;
  logic [2*WIDTH-1:0] prod;
  assign start = state_q == IDLE && (bus.ctrl_MULT || bus.ctrl_DIV);
  assign a_neg = bus.ctrl_signed && bus.data_operandA[WIDTH-1];
  assign b_neg = bus.ctrl_signed && bus.data_operandB[WIDTH-1];
  assign mag_a = a_neg ? -bus.data_operandA : bus.data_operandA;
  assign mag_b = b_neg ? -bus.data_operandB : bus.data_operandB;
  // Divide subtracts from the shifted remainder; multiply adds into the upper half.
  assign trial = {acc_q, low_q[WIDTH-1]};
  assign sum = (div_q ? {1'b0, trial} : {2'b0, acc_q})
             + (div_q ? ~{2'b0, m_q} : {2'b0, m_q})
             + {{(WIDTH+1){1'b0}}, div_q};
  assign prod = neg_q ? -{acc_q, low_q} : {acc_q, low_q};
  assign quo = neg_q ? -low_q : low_q;
  assign rem = dneg_q ? -acc_q : acc_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    low_d = low_q;
    m_d = m_q;
    div_d = div_q;
    sgn_d = sgn_q;
    neg_d = neg_q;
    dneg_d = dneg_q;
    dz_d = dz_q;
    res_d = res_q;
    exc_d = exc_q;
    rdy_d = 1'b0;
    busy_d = busy_q;
    if (state_q == IDLE) begin
      if (start) begin
        div_d = !bus.ctrl_MULT;
        sgn_d = bus.ctrl_signed;
        neg_d = a_neg ^ b_neg;
        dneg_d = a_neg;
        m_d = bus.ctrl_MULT ? mag_a : mag_b;
        low_d = bus.ctrl_MULT ? mag_b : mag_a;
        acc_d = '0;
        cnt_d = CNT_W'(WIDTH);
        dz_d = !bus.ctrl_MULT && bus.data_operandB == '0;
        state_d = dz_d ? FIX : RUN;
        busy_d = 1'b1;
        exc_d = 1'b0;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      state_d = cnt_q == CNT_W'(1) ? FIX : RUN;
      if (div_q) begin
        acc_d = sum[WIDTH+1] ? trial[WIDTH-1:0] : sum[WIDTH-1:0];
        low_d = {low_q[WIDTH-2:0], !sum[WIDTH+1]};
      end else begin
        acc_d = low_q[0] ? sum[WIDTH:1] : {1'b0, acc_q[WIDTH-1:1]};
        low_d = {low_q[0] ? sum[0] : acc_q[0], low_q[WIDTH-1:1]};
      end
    end else begin
      state_d = IDLE;
      busy_d = 1'b0;
      rdy_d = 1'b1;
      res_d = dz_q ? '0 : div_q ? {rem, quo} : prod;
      exc_d = dz_q || (div_q ? sgn_q && !neg_q && low_q[WIDTH-1]
                     : sgn_q ? prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}}
                     : acc_q != '0);
    end
  end
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      low_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
      dneg_q <= 1'b0;
      dz_q <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      low_q <= low_d;
      m_q <= m_d;
      div_q <= div_d;
      sgn_q <= sgn_d;
      neg_q <= neg_d;
      dneg_q <= dneg_d;
      dz_q <= dz_d;
      res_q <= res_d;
      exc_q <= exc_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
    end
  end
  assign bus.data_result = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed and random multiply/divide checks against an arithmetic reference model
module tb_multdiv_seq;
  logic clock, clrn;
  int vectors, miscompares, cyc;
  logic [63:0] exp_res;
  multdiv_seq_if #(.WIDTH(32)) bif ();
  multdiv_seq #(.WIDTH(32)) dut (.clock(clock), .clrn(clrn), .bus(bif));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [64:0] model(input bit m, input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int q, r;
    if (m && s) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return {sp != longint'(int'(sp)), sp};
    end
    if (m) begin
      up = {32'b0, a} * {32'b0, b};
      return {up[63:32] != 32'b0, up};
    end
    if (b == 32'b0) return {1'b1, 64'b0};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'b0, 32'h8000_0000};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {1'b0, r, q};
    end
    return {1'b0, a % b, a / b};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clock);
    cyc++;
  endtask
  task automatic start(input bit m, input bit d, input bit s, input logic [31:0] a, input logic [31:0] b, input bit sync);
    if (sync) @(negedge clock);
    bif.data_operandA = a;
    bif.data_operandB = b;
    bif.ctrl_MULT = m;
    bif.ctrl_DIV = d;
    bif.ctrl_signed = s;
    @(negedge clock);
    cyc = 0;
    bif.ctrl_MULT = 1'b0;
    bif.ctrl_DIV = 1'b0;
    bif.ctrl_signed = $urandom_range(0, 1);
    bif.data_operandA = $urandom;
    bif.data_operandB = $urandom;
    chk("busy_set", {63'b0, bif.busy}, 64'd1);
    chk("rdy_clr", {63'b0, bif.data_resultRDY}, 64'd0);
  endtask
  task automatic wait_rdy(input int lat, input string tag);
    while (!bif.data_resultRDY && cyc < 200) step();
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_busy"}, {63'b0, bif.busy}, 64'd0);
  endtask
  task automatic do_op(input bit m, input bit d, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input bit sync, input string tag);
    logic [64:0] e;
    e = model(m, s, a, b);
    start(m, d, s, a, b, sync);
    wait_rdy((!m && b == 32'b0) ? 1 : 33, tag);
    chk({tag, "_res"}, bif.data_result, e[63:0]);
    chk({tag, "_exc"}, {63'b0, bif.data_exception}, {63'b0, e[64]});
    exp_res = e[63:0];
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    clrn = 1'b0;
    bif.data_operandA = '0;
    bif.data_operandB = '0;
    bif.ctrl_MULT = 1'b0;
    bif.ctrl_DIV = 1'b0;
    bif.ctrl_signed = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_res", bif.data_result, 64'd0);
    chk("rst_flags", {60'b0, bif.data_exception, bif.data_resultRDY, bif.busy, 1'b0}, 64'd0);
    clrn = 1'b1;
    do_op(1, 0, 1, 32'd7, -32'sd3, 1, "mul_s_7x-3");
    chk("mul_s_const", bif.data_result, 64'hFFFF_FFFF_FFFF_FFEB);
    step();
    chk("rdy_pulse", {63'b0, bif.data_resultRDY}, 64'd0);
    chk("res_held", bif.data_result, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(1, 0, 1, 32'h0001_0000, 32'h0001_0000, 1, "mul_s_ovf");
    chk("mul_s_ovf_const", bif.data_result, 64'h0000_0001_0000_0000);
    do_op(1, 0, 0, 32'h0001_0000, 32'h0001_0000, 1, "mul_u_ovf");
    do_op(1, 0, 0, 32'hFFFF_FFFF, 32'd2, 1, "mul_u_max");
    chk("mul_u_max_const", bif.data_result, 64'h0000_0001_FFFF_FFFE);
    do_op(1, 0, 1, 32'h8000_0000, 32'd1, 1, "mul_s_min");
    do_op(1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "mul_s_minneg");
    do_op(0, 1, 1, -32'sd7, 32'd2, 1, "div_s_-7/2");
    chk("div_s_const", bif.data_result, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(0, 1, 0, 32'd100, 32'd7, 1, "div_u_100/7");
    chk("div_u_const", bif.data_result, {32'd2, 32'd14});
    do_op(0, 1, 0, 32'd5, 32'd0, 1, "div_zero");
    do_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_min_neg1");
    chk("div_min_const", bif.data_result, 64'h0000_0000_8000_0000);
    start(1, 0, 0, 32'd1234, 32'd5678, 1);
    repeat (4) step();
    bif.ctrl_DIV = 1'b1;
    step();
    bif.ctrl_DIV = 1'b0;
    wait_rdy(33, "ignore_div");
    chk("ignore_div_res", bif.data_result, 64'd7006652);
    do_op(1, 1, 1, -32'sd9, 32'd11, 1, "both_mult");
    do_op(0, 1, 0, 32'd1000, 32'd3, 0, "b2b_first");
    do_op(1, 0, 0, 32'hDEAD_BEEF, 32'h1234_5678, 0, "b2b_second");
    start(1, 0, 1, 32'h0000_ABCD, 32'hFFFF_0123, 1);
    while (cyc < 10) step();
    #2 clrn = 1'b0;
    #1;
    chk("arst_res", bif.data_result, 64'd0);
    chk("arst_flags", {60'b0, bif.data_exception, bif.data_resultRDY, bif.busy, 1'b0}, 64'd0);
    repeat (3) begin
      step();
      chk("arst_no_rdy", {63'b0, bif.data_resultRDY}, 64'd0);
    end
    clrn = 1'b1;
    do_op(0, 1, 1, 32'd12345, -32'sd67, 1, "post_rst_div");
    for (int i = 0; i < 40; i++) begin
      logic m, s;
      logic [31:0] a, b;
      int sel;
      m = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'b0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) a = $urandom_range(0, 255);
      do_op(m, m ? 1'($urandom_range(0, 1)) : 1'b1, s, a, b, $urandom_range(0, 1), "rand");
      step();
      chk("rand_pulse", {63'b0, bif.data_resultRDY}, 64'd0);
      chk("rand_held", bif.data_result, exp_res);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
